// File: rtl/led_pattern_gen_if.sv
// Control and drive bundle between the LED control registers and the pattern generator.
interface led_pattern_gen_if #(
    parameter int N_LEDS      = 4,
    parameter int P_PWM_WIDTH = 8
) ();
    logic                   en;
    logic [1:0]             mode;
    logic [1:0]             period_sel;
    logic [P_PWM_WIDTH-1:0] pwm_lvl;
    logic [N_LEDS-1:0]      fixed_pattern;
    logic [N_LEDS-1:0]      led_out;
    logic                   step_pulse;

    modport master (
        output en, mode, period_sel, pwm_lvl, fixed_pattern,
        input  led_out, step_pulse
    );

    modport slave (
        input  en, mode, period_sel, pwm_lvl, fixed_pattern,
        output led_out, step_pulse
    );
endinterface

// File: rtl/led_pattern_gen.sv
// N-LED pattern generator: fixed / scanner / binary count / rotate modes with
// a power-of-two step divider and global PWM dimming.
//
// scan direction state (only meaningful in scanner mode)
//   state    | meaning
//   DIR_UP   | position increments on each step; flips at the top LED
//   DIR_DOWN | position decrements on each step; flips at LED 0
module led_pattern_gen #(
    parameter int N_LEDS      = 4,
    parameter int P_DIV_WIDTH = 24,
    parameter int P_PWM_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    led_pattern_gen_if.slave ctl
);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] ONE_HOT0 = N_LEDS'(1);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    typedef enum logic [1:0] {MODE_FIXED, MODE_SCAN, MODE_COUNT, MODE_ROT} mode_t;

    mode_t                  mode_q,     mode_nxt;
    logic [1:0]             sel_q,      sel_nxt;
    logic [P_DIV_WIDTH-1:0] div,        div_nxt;
    logic [N_LEDS-1:0]      pattern,    pattern_nxt;
    logic [POS_W-1:0]       pos,        pos_nxt;
    dir_t                   dir,        dir_nxt;
    logic [P_PWM_WIDTH-1:0] pwm_cnt,    pwm_cnt_nxt;
    logic [N_LEDS-1:0]      led_q,      led_nxt;
    logic                   step_q,     step_nxt;
    logic [P_DIV_WIDTH-1:0] div_term;
    logic                   pwm_on;

    // Terminal count 2^(W-4+sel)-1 is the all-ones word shifted down by 4-sel.
    assign div_term = {P_DIV_WIDTH{1'b1}} >> (3'd4 - {1'b0, sel_q});
    assign pwm_on   = (pwm_cnt < ctl.pwm_lvl) || (&ctl.pwm_lvl);

    assign ctl.led_out    = led_q;
    assign ctl.step_pulse = step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_FIXED;
            sel_q   <= '0;
            div     <= '0;
            pattern <= '0;
            pos     <= '0;
            dir     <= DIR_UP;
            pwm_cnt <= '0;
            led_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            mode_q  <= mode_nxt;
            sel_q   <= sel_nxt;
            div     <= div_nxt;
            pattern <= pattern_nxt;
            pos     <= pos_nxt;
            dir     <= dir_nxt;
            pwm_cnt <= pwm_cnt_nxt;
            led_q   <= led_nxt;
            step_q  <= step_nxt;
        end
    end

    always_comb begin
        mode_nxt    = mode_q;
        sel_nxt     = sel_q;
        div_nxt     = div;
        pattern_nxt = pattern;
        pos_nxt     = pos;
        dir_nxt     = dir;
        step_nxt    = 1'b0;
        pwm_cnt_nxt = ctl.en ? pwm_cnt + 1'b1 : '0;
        led_nxt     = ctl.en ? (pattern & {N_LEDS{pwm_on}}) : '0;

        if (ctl.mode != mode_q) begin
            // Reseed wins over any tick; period select is captured alongside.
            mode_nxt = mode_t'(ctl.mode);
            sel_nxt  = ctl.period_sel;
            div_nxt  = '0;
            case (ctl.mode)
                2'd0: pattern_nxt = ctl.fixed_pattern;
                2'd1: begin
                    pos_nxt     = '0;
                    dir_nxt     = DIR_UP;
                    pattern_nxt = ONE_HOT0;
                end
                2'd2: pattern_nxt = '0;
                default: pattern_nxt = (ctl.fixed_pattern == '0) ? ONE_HOT0 : ctl.fixed_pattern;
            endcase
        end else begin
            if (ctl.period_sel != sel_q) begin
                sel_nxt = ctl.period_sel;
                div_nxt = '0;
            end else if (!ctl.en) begin
                div_nxt = '0;
            end else if (div == div_term) begin
                div_nxt  = '0;
                step_nxt = 1'b1;
                case (mode_q)
                    MODE_SCAN: begin
                        if (N_LEDS > 1) begin
                            if (dir == DIR_UP) begin
                                if (pos == POS_LAST) begin
                                    pos_nxt = pos - 1'b1;
                                    dir_nxt = DIR_DOWN;
                                end else begin
                                    pos_nxt = pos + 1'b1;
                                end
                            end else begin
                                if (pos == '0) begin
                                    pos_nxt = pos + 1'b1;
                                    dir_nxt = DIR_UP;
                                end else begin
                                    pos_nxt = pos - 1'b1;
                                end
                            end
                        end
                        pattern_nxt = ONE_HOT0 << pos_nxt;
                    end
                    MODE_COUNT: pattern_nxt = pattern + 1'b1;
                    MODE_ROT:   pattern_nxt = (pattern << 1) | (pattern >> (N_LEDS - 1));
                    default:    pattern_nxt = pattern;
                endcase
            end else begin
                div_nxt = div + 1'b1;
            end

            // Fixed mode tracks its input continuously while enabled.
            if (ctl.en && (mode_q == MODE_FIXED)) begin
                pattern_nxt = ctl.fixed_pattern;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a step-index reference model.
module tb_led_pattern_gen;
    localparam int N  = 4;
    localparam int DW = 5;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #4 clk = ~clk;

    led_pattern_gen_if #(.N_LEDS(N), .P_PWM_WIDTH(PW)) bus ();

    led_pattern_gen #(.N_LEDS(N), .P_DIV_WIDTH(DW), .P_PWM_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: pattern is a pure function of mode, steps taken since reseed and seed.
    int         m_mode, m_sel, m_cnt, m_idx, m_pwm;
    logic [3:0] m_seed, m_fixed, m_led;
    logic       m_step;

    function automatic logic [3:0] mpat();
        int ph, p;
        logic [7:0] t;
        case (m_mode)
            0: mpat = m_fixed;
            1: begin
                ph   = m_idx % 6;
                p    = (ph < 4) ? ph : 6 - ph;
                mpat = 4'(1 << p);
            end
            2: mpat = 4'(m_idx % 16);
            default: begin
                p    = m_idx % 4;
                t    = {m_seed, m_seed} << p;
                mpat = t[7:4];
            end
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_cnt = 0; m_idx = 0; m_pwm = 0;
        m_seed = 4'h0; m_fixed = 4'h0; m_led = 4'h0; m_step = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] p_old;
        bit on;
        p_old  = mpat();
        on     = (m_pwm < int'(bus.pwm_lvl)) || (bus.pwm_lvl == 4'hF);
        m_led  = (bus.en && on) ? p_old : 4'h0;
        m_step = 1'b0;
        if (int'(bus.mode) != m_mode) begin
            m_mode  = int'(bus.mode);
            m_sel   = int'(bus.period_sel);
            m_cnt   = 0;
            m_idx   = 0;
            m_fixed = bus.fixed_pattern;
            m_seed  = (bus.fixed_pattern == 4'h0) ? 4'h1 : bus.fixed_pattern;
        end else begin
            if (int'(bus.period_sel) != m_sel) begin
                m_sel = int'(bus.period_sel);
                m_cnt = 0;
            end else if (!bus.en) begin
                m_cnt = 0;
            end else if (m_cnt == (2 << m_sel) - 1) begin
                m_cnt  = 0;
                m_step = 1'b1;
                m_idx++;
            end else begin
                m_cnt++;
            end
            if (bus.en && m_mode == 0) m_fixed = bus.fixed_pattern;
        end
        m_pwm = bus.en ? (m_pwm + 1) % 16 : 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Continuous scoreboard against the model, sampled well clear of the clock edge.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            total++;
            if (bus.led_out !== m_led) begin
                bad++;
                $display("FAIL model_led t=%0t got=%h exp=%h", $time, bus.led_out, m_led);
            end
            total++;
            if (bus.step_pulse !== m_step) begin
                bad++;
                $display("FAIL model_step t=%0t got=%b exp=%b", $time, bus.step_pulse, m_step);
            end
        end
    end

    task automatic test_reset();
        int n;
        bit found;
        rst_n = 1'b0;
        bus.en = 1'b1; bus.mode = 2'd1; bus.period_sel = 2'd0;
        bus.pwm_lvl = 4'hF; bus.fixed_pattern = 4'h0;
        model_reset();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (bus.led_out !== 4'h0 || bus.step_pulse !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold got=%h/%b exp=0/0", bus.led_out, bus.step_pulse);
            end
        end
        rst_n = 1'b1;
        n = 0; found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n++;
            if (bus.step_pulse) begin found = 1'b1; break; end
        end
        // reseed edge plus two cycles of period 2
        total++;
        if (!found || n != 3) begin
            bad++;
            $display("FAIL reset_first_step got=%0d exp=3", n);
        end
    endtask

    task automatic test_scanner();
        logic [3:0] exp_s [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        logic [3:0] seq [8];
        int since, idx;
        bit rec;
        bus.en = 1'b1; bus.pwm_lvl = 4'hF; bus.period_sel = 2'd3;
        bus.mode = 2'd2; cyc();
        bus.mode = 2'd1; cyc();
        cyc();
        seq[0] = bus.led_out;
        since = 1; idx = 1; rec = 1'b0;
        for (int c = 0; c < 200 && idx < 8; c++) begin
            cyc();
            since++;
            if (rec) begin seq[idx] = bus.led_out; idx++; rec = 1'b0; end
            if (bus.step_pulse) begin
                total++;
                if (since != 16) begin
                    bad++;
                    $display("FAIL scan_spacing got=%0d exp=16", since);
                end
                since = 0;
                rec = 1'b1;
            end
        end
        total++;
        if (idx != 8) begin
            bad++;
            $display("FAIL scan_timeout got=%0d exp=8 samples", idx);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seq[i] !== exp_s[i]) begin
                bad++;
                $display("FAIL scan_seq[%0d] got=%h exp=%h", i, seq[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_count_wrap();
        int ns;
        bit rec;
        bus.en = 1'b1; bus.pwm_lvl = 4'hF; bus.period_sel = 2'd0;
        bus.mode = 2'd3; cyc();
        bus.mode = 2'd2; cyc();
        ns = 0; rec = 1'b0;
        for (int c = 0; c < 32; c++) begin
            cyc();
            if (rec) begin
                total++;
                if (bus.led_out !== 4'(ns % 16)) begin
                    bad++;
                    $display("FAIL count_val got=%h exp=%h", bus.led_out, 4'(ns % 16));
                end
                rec = 1'b0;
            end
            if (bus.step_pulse) begin ns++; rec = 1'b1; end
        end
        total++;
        if (ns != 16) begin
            bad++;
            $display("FAIL count_steps got=%0d exp=16", ns);
        end
        cyc();
    endtask

    task automatic test_rotate();
        logic [3:0] exp_a [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        logic [3:0] exp_b [5] = '{4'h9, 4'h3, 4'h6, 4'hC, 4'h9};
        logic [3:0] seq [5];
        logic [3:0] want;
        int idx;
        bit rec;
        bus.en = 1'b1; bus.pwm_lvl = 4'hF; bus.period_sel = 2'd0;
        for (int r = 0; r < 2; r++) begin
            bus.fixed_pattern = (r == 0) ? 4'h0 : 4'h9;
            bus.mode = (r == 0) ? 2'd2 : 2'd0; cyc();
            bus.mode = 2'd3; cyc();
            cyc();
            seq[0] = bus.led_out;
            idx = 1; rec = 1'b0;
            for (int c = 0; c < 40 && idx < 5; c++) begin
                cyc();
                if (rec) begin seq[idx] = bus.led_out; idx++; rec = 1'b0; end
                if (bus.step_pulse) rec = 1'b1;
            end
            for (int i = 0; i < 5; i++) begin
                want = (r == 0) ? exp_a[i] : exp_b[i];
                total++;
                if (seq[i] !== want) begin
                    bad++;
                    $display("FAIL rotate_seq r%0d[%0d] got=%h exp=%h", r, i, seq[i], want);
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [3:0] lvls [3] = '{4'h4, 4'h0, 4'hF};
        int         exps [3] = '{4, 0, 16};
        int on_cnt;
        bus.en = 1'b1; bus.period_sel = 2'd0;
        bus.mode = 2'd1; cyc();
        bus.mode = 2'd0; bus.fixed_pattern = 4'hF;
        for (int r = 0; r < 3; r++) begin
            bus.pwm_lvl = lvls[r];
            cyc(); cyc();
            on_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                cyc();
                if (bus.led_out == 4'hF) on_cnt++;
            end
            total++;
            if (on_cnt != exps[r]) begin
                bad++;
                $display("FAIL pwm_duty lvl=%h got=%0d exp=%0d", lvls[r], on_cnt, exps[r]);
            end
        end
        bus.pwm_lvl = 4'hF;
    endtask

    task automatic test_enable_period();
        bit found;
        int n;
        bus.en = 1'b1; bus.pwm_lvl = 4'hF; bus.period_sel = 2'd1;
        bus.mode = 2'd2; cyc();
        bus.mode = 2'd1; cyc();
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (bus.led_out == 4'h4) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL en_reach_pos2 got=%h exp=4", bus.led_out);
        end
        bus.en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) bus.period_sel = 2'd2;
            cyc();
            total++;
            if (bus.led_out !== 4'h0 || bus.step_pulse !== 1'b0) begin
                bad++;
                $display("FAIL en_low got=%h/%b exp=0/0", bus.led_out, bus.step_pulse);
            end
        end
        bus.en = 1'b1;
        cyc();
        total++;
        if (bus.led_out !== 4'h4) begin
            bad++;
            $display("FAIL en_resume got=%h exp=4", bus.led_out);
        end
        n = 1; found = bus.step_pulse;
        for (int c = 0; c < 30 && !found; c++) begin
            cyc();
            n++;
            found = bus.step_pulse;
        end
        total++;
        if (!found || n != 8) begin
            bad++;
            $display("FAIL en_first_step got=%0d exp=8", n);
        end
        cyc();
        total++;
        if (bus.led_out !== 4'h8) begin
            bad++;
            $display("FAIL en_next_pos got=%h exp=8", bus.led_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.period_sel = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) bus.fixed_pattern = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.pwm_lvl = 4'($urandom_range(0, 15));
            if (c == 300) begin
                bus.pwm_lvl = 4'hF;
                do_reset();
            end
            cyc();
        end
        total++;
        if (int'(bus.mode) != m_mode) begin
            bad++;
            $display("FAIL rand_mode_track got=%0d exp=%0d", bus.mode, m_mode);
        end
    endtask

    initial begin
        test_reset();
        test_scanner();
        test_count_wrap();
        test_rotate();
        test_pwm();
        test_enable_period();
        test_random();
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end
endmodule
